// File: rtl/integration_scheduler.sv
// Integration scheduler: sample/integration strobes plus a byte-serial dump of the correlation snapshot.
// Define INTEG_HEADER_EN to prefix each dump with 0xA5 and an 8-bit frame counter.
module integration_scheduler #(
   parameter int SAMPLE_DIV   = 50,
   parameter int NUM_CHANNELS = 78,
   parameter int RESOLUTION   = 14
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  stop,
   input  logic [23:0]           int_len,
   output logic                  sample_clk_pulse,
   output logic                  integration_clk_pulse,
   output logic [7:0]            rd_addr,
   input  logic [RESOLUTION-1:0] rd_data,
   output logic [7:0]            tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   output logic                  busy,
   output logic                  overrun
);

   // tx handshake: a byte is held on tx_data with tx_valid high and moves on only
   // in a cycle where tx_valid && tx_ready; tx_data never changes while unaccepted.

   localparam int DIV_W = $clog2(SAMPLE_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
   localparam logic [7:0]       LAST_ADDR = 8'(NUM_CHANNELS - 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} int_state_t;
   typedef enum logic [2:0] {D_IDLE, D_HDR, D_FETCH, D_HI, D_LO} dump_state_t;

   int_state_t  state;
   dump_state_t d_state;

   logic [DIV_W-1:0] div_cnt;
   logic [23:0]      int_len_q;
   logic [23:0]      samp_cnt;
   logic             fetch_wait;
   logic [7:0]       lo_hold;
`ifdef INTEG_HEADER_EN
   logic [7:0]       frame_cnt;
   logic             hdr_second;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state                 <= IDLE;
         div_cnt               <= '0;
         samp_cnt              <= '0;
         int_len_q             <= 24'd1;
         sample_clk_pulse      <= 1'b0;
         integration_clk_pulse <= 1'b0;
         busy                  <= 1'b0;
      end else begin
         sample_clk_pulse      <= 1'b0;
         integration_clk_pulse <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state     <= RUN;
                  busy      <= 1'b1;
                  int_len_q <= (int_len == 24'd0) ? 24'd1 : int_len;
                  div_cnt   <= '0;
                  samp_cnt  <= '0;
               end
            end
            RUN: begin
               if (stop) begin
                  state <= DRAIN;
               end else if (div_cnt == DIV_LAST) begin
                  div_cnt          <= '0;
                  sample_clk_pulse <= 1'b1;
                  if (samp_cnt == int_len_q - 24'd1) begin
                     samp_cnt              <= '0;
                     integration_clk_pulse <= 1'b1;
                  end else begin
                     samp_cnt <= samp_cnt + 24'd1;
                  end
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            DRAIN: begin
               // a pulse raised just before stop still starts its dump; wait for it too
               if (d_state == D_IDLE && !integration_clk_pulse) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         d_state    <= D_IDLE;
         rd_addr    <= '0;
         tx_data    <= '0;
         tx_valid   <= 1'b0;
         overrun    <= 1'b0;
         fetch_wait <= 1'b0;
         lo_hold    <= '0;
`ifdef INTEG_HEADER_EN
         frame_cnt  <= '0;
         hdr_second <= 1'b0;
`endif
      end else begin
         if (state == IDLE && start)
            overrun <= 1'b0;
         else if (integration_clk_pulse && d_state != D_IDLE)
            overrun <= 1'b1;

         case (d_state)
            D_IDLE: begin
               if (integration_clk_pulse) begin
`ifdef INTEG_HEADER_EN
                  d_state    <= D_HDR;
                  tx_data    <= 8'hA5;
                  tx_valid   <= 1'b1;
                  hdr_second <= 1'b0;
`else
                  d_state    <= D_FETCH;
                  rd_addr    <= '0;
                  fetch_wait <= 1'b0;
`endif
               end
            end
`ifdef INTEG_HEADER_EN
            D_HDR: begin
               if (tx_valid && tx_ready) begin
                  if (!hdr_second) begin
                     hdr_second <= 1'b1;
                     tx_data    <= frame_cnt;
                  end else begin
                     tx_valid   <= 1'b0;
                     rd_addr    <= '0;
                     fetch_wait <= 1'b0;
                     d_state    <= D_FETCH;
                  end
               end
            end
`endif
            D_FETCH: begin
               // rd_data lags rd_addr by one cycle
               if (!fetch_wait) begin
                  fetch_wait <= 1'b1;
               end else begin
                  lo_hold  <= rd_data[7:0];
                  tx_data  <= 8'(rd_data >> 8);
                  tx_valid <= 1'b1;
                  d_state  <= D_HI;
               end
            end
            D_HI: begin
               if (tx_valid && tx_ready) begin
                  tx_data <= lo_hold;
                  d_state <= D_LO;
               end
            end
            D_LO: begin
               if (tx_valid && tx_ready) begin
                  tx_valid <= 1'b0;
                  if (rd_addr == LAST_ADDR) begin
                     d_state <= D_IDLE;
`ifdef INTEG_HEADER_EN
                     frame_cnt <= frame_cnt + 8'd1;
`endif
                  end else begin
                     rd_addr    <= rd_addr + 8'd1;
                     fetch_wait <= 1'b0;
                     d_state    <= D_FETCH;
                  end
               end
            end
            default: d_state <= D_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_integration_scheduler.sv
// Directed bench for integration_scheduler (SAMPLE_DIV=4, NUM_CHANNELS=2, RESOLUTION=14).
// Follows INTEG_HEADER_EN so the expected dumps match either build.
module tb_integration_scheduler;

   localparam int SDIV = 4;
   localparam int NCH  = 2;
   localparam int RES  = 14;
`ifdef INTEG_HEADER_EN
   localparam int HDR = 2;
`else
   localparam int HDR = 0;
`endif

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           start = 1'b0;
   logic           stop = 1'b0;
   logic [23:0]    int_len = 24'd0;
   logic           sample_clk_pulse;
   logic           integration_clk_pulse;
   logic [7:0]     rd_addr;
   logic [RES-1:0] rd_data = '0;
   logic [7:0]     tx_data;
   logic           tx_valid;
   logic           tx_ready = 1'b0;
   logic           busy;
   logic           overrun;

   logic [7:0] got_q[$];
   logic [7:0] exp_q[$];
   int cmp_cnt = 0;
   int mis_cnt = 0;
   int sp_seen;
   int ip_seen;
   int waited_ok;

   integration_scheduler #(.SAMPLE_DIV(SDIV), .NUM_CHANNELS(NCH), .RESOLUTION(RES)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .int_len(int_len),
      .sample_clk_pulse(sample_clk_pulse), .integration_clk_pulse(integration_clk_pulse),
      .rd_addr(rd_addr), .rd_data(rd_data), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .busy(busy), .overrun(overrun)
   );

   // clock / snapshot memory model / byte monitor
   always #5 clk = ~clk;

   always @(posedge clk) rd_data <= (rd_addr != 8'd0) ? 14'h1ABC : 14'h0123;

   always @(posedge clk) if (rst_n && tx_valid && tx_ready) got_q.push_back(tx_data);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      cmp_cnt++;
      assert (obs === exp) else begin
         mis_cnt++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start(input logic [23:0] len);
      int_len = len;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      tick();
      stop = 1'b0;
   endtask

   // waits for busy to drop, counting strobes seen on the way
   task automatic wait_idle(input int budget);
      sp_seen = 0;
      ip_seen = 0;
      waited_ok = 0;
      for (int i = 0; i < budget; i++) begin
         if (!busy) begin
            waited_ok = 1;
            break;
         end
         if (sample_clk_pulse) sp_seen++;
         if (integration_clk_pulse) ip_seen++;
         tick();
      end
   endtask

   task automatic wait_bytes(input int n, input int budget);
      waited_ok = 0;
      for (int i = 0; i < budget; i++) begin
         if (got_q.size() >= n) begin
            waited_ok = 1;
            break;
         end
         tick();
      end
   endtask

   task automatic build_exp(input logic [7:0] frame);
      exp_q.delete();
`ifdef INTEG_HEADER_EN
      exp_q.push_back(8'hA5);
      exp_q.push_back(frame);
`else
      if (frame != 8'd0) exp_q.delete();
`endif
      exp_q.push_back(8'h01);
      exp_q.push_back(8'h23);
      exp_q.push_back(8'h1A);
      exp_q.push_back(8'hBC);
   endtask

   task automatic check_bytes(input string tag, input logic [7:0] frame);
      int n;
      build_exp(frame);
      chk({tag, "_len"}, got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         chk($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_sample"}, sample_clk_pulse, 0);
      chk({tag, "_integ"}, integration_clk_pulse, 0);
      chk({tag, "_rd_addr"}, rd_addr, 0);
      chk({tag, "_tx_data"}, tx_data, 0);
      chk({tag, "_tx_valid"}, tx_valid, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_overrun"}, overrun, 0);
   endtask

   initial begin
      // reset state
      repeat (3) tick();
      check_reset_outputs("reset");
      rst_n = 1'b1;
      tick();

      // strobe timing: int_len=3 -> pulses 4,8,12 cycles after start, integration on 12
      tx_ready = 1'b1;
      got_q.delete();
      pulse_start(24'd3);
      chk("run_busy", busy, 1);
      for (int k = 1; k <= 12; k++) begin
         tick();
         chk($sformatf("sample_c%0d", k), sample_clk_pulse, (k % 4 == 0));
         chk($sformatf("integ_c%0d", k), integration_clk_pulse, (k == 12));
      end
      // stop while the first dump is in flight
      tick();
      pulse_stop();
      wait_idle(80);
      chk("drainA_done", waited_ok, 1);
      chk("drainA_samples", sp_seen, 0);
      chk("drainA_integ", ip_seen, 0);
      chk("drainA_tx_valid", tx_valid, 0);
      chk("drainA_overrun", overrun, 0);
      check_bytes("dumpA", 8'd0);

      // backpressure: tx_ready low for 10 cycles right after the first data byte
      got_q.delete();
      pulse_start(24'd10);
      wait_bytes(HDR + 1, 300);
      chk("stallB_reached", waited_ok, 1);
      tx_ready = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         chk($sformatf("stallB_valid%0d", k), tx_valid, 1);
         chk($sformatf("stallB_data%0d", k), tx_data, 8'h23);
      end
      chk("stallB_count", got_q.size(), HDR + 1);
      tx_ready = 1'b1;
      pulse_stop();
      wait_idle(80);
      chk("drainB_done", waited_ok, 1);
      check_bytes("dumpB", 8'd1);

      // overrun: tx_ready held low across several integrations
      got_q.delete();
      tx_ready = 1'b0;
      pulse_start(24'd1);
      repeat (14) tick();
      chk("ovrC_flag", overrun, 1);
      chk("ovrC_nobytes", got_q.size(), 0);
      chk("ovrC_valid", tx_valid, 1);
      pulse_stop();
      tx_ready = 1'b1;
      wait_idle(80);
      chk("drainC_done", waited_ok, 1);
      chk("drainC_overrun_sticky", overrun, 1);
      check_bytes("dumpC", 8'd2);

      // start clears overrun; reset mid-dump abandons it
      pulse_start(24'd5);
      chk("startD_overrun_clr", overrun, 0);
      waited_ok = 0;
      for (int i = 0; i < 100; i++) begin
         if (tx_valid) begin
            waited_ok = 1;
            break;
         end
         tick();
      end
      chk("midD_reached", waited_ok, 1);
      rst_n = 1'b0;
      tick();
      check_reset_outputs("midreset");
      rst_n = 1'b1;
      got_q.delete();
      pulse_start(24'd5);
      wait_bytes(HDR + 2 * NCH, 200);
      chk("dumpE_reached", waited_ok, 1);
      pulse_stop();
      wait_idle(80);
      chk("drainE_done", waited_ok, 1);
      check_bytes("dumpE", 8'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
      $finish;
   end

endmodule

// File: doc/integration_scheduler.md
INTEGRATION_SCHEDULER -- requirements
Module: integration_scheduler

Interface
REQ-001 SHALL have parameter SAMPLE_DIV, default 50, meaning clocks per sample_clk_pulse (>=2).
REQ-002 SHALL have parameter NUM_CHANNELS, default 78, meaning correlation words per dump (>=1).
REQ-003 SHALL have parameter RESOLUTION, default 14, meaning correlation word width (9..16).
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all logic rising-edge.
REQ-005 SHALL have port rst_n, input, 1 bit, synchronous active-low reset.
REQ-006 SHALL have port start, input, 1 bit, one-cycle pulse that begins continuous integration.
REQ-007 SHALL have port stop, input, 1 bit, one-cycle pulse that ends integration after the current dump.
REQ-008 SHALL have port int_len, input, 24 bits, samples per integration, latched at start.
REQ-009 SHALL have port sample_clk_pulse, output, 1 bit, one-cycle ADC sample strobe.
REQ-010 SHALL have port integration_clk_pulse, output, 1 bit, one-cycle strobe: datapath snapshots and clears counters.
REQ-011 SHALL have port rd_addr, output, 8 bits, snapshot word index.
REQ-012 SHALL have port rd_data, input, RESOLUTION bits, snapshot word, valid the cycle after rd_addr changes.
REQ-013 SHALL have port tx_data, output, 8 bits, byte to UART transmitter.
REQ-014 SHALL have port tx_valid, output, 1 bit, tx_data valid.
REQ-015 SHALL have port tx_ready, input, 1 bit, transmitter accepts byte when tx_valid and tx_ready are both high.
REQ-016 SHALL have port busy, output, 1 bit, high outside IDLE.
REQ-017 SHALL have port overrun, output, 1 bit, sticky: a dump was skipped.

Function
REQ-018 Integration FSM states SHALL be IDLE, RUN, DRAIN; start in IDLE -> RUN, latching int_len (0 treated as 1) and clearing the sample divider and sample count.
REQ-019 In RUN, sample_clk_pulse SHALL assert exactly one cycle every SAMPLE_DIV clocks, first pulse SAMPLE_DIV clocks after entering RUN.
REQ-020 On the int_len-th sample_clk_pulse, integration_clk_pulse SHALL assert in the same cycle, the sample count SHALL reset to 0, and integration SHALL continue without gap.
REQ-021 Each integration_clk_pulse SHALL request a dump; dump sequencer states SHALL be D_IDLE, D_HDR, D_FETCH, D_HI, D_LO.
REQ-022 Dump SHALL emit, per word 0..NUM_CHANNELS-1 ascending, byte {zero-padded rd_data[RESOLUTION-1:8]} then byte rd_data[7:0].
REQ-023 D_FETCH SHALL drive rd_addr and wait one cycle before capturing rd_data into a holding register.
REQ-024 tx_valid SHALL stay high with tx_data stable until accepted; a byte SHALL advance only on tx_valid&&tx_ready.
REQ-025 Integration_clk_pulse while a dump is in progress SHALL NOT restart the dump, SHALL set overrun, and that dump SHALL be dropped.
REQ-026 stop in RUN SHALL go to DRAIN: sample pulses cease immediately, no further integration_clk_pulse; a dump in progress completes, then IDLE.
REQ-027 start while busy SHALL be ignored; stop in IDLE SHALL be ignored; start and stop in the same IDLE cycle: start wins, stop ignored.
REQ-028 overrun SHALL clear only on reset or on start accepted in IDLE.

Reset
REQ-029 rst_n low at a clock edge SHALL force IDLE and D_IDLE, abandoning any partial dump; no byte completion is owed.
REQ-030 Reset values SHALL be: sample_clk_pulse 0, integration_clk_pulse 0, rd_addr 0, tx_data 0, tx_valid 0, busy 0, overrun 0.

Configuration
REQ-031 Macro INTEG_HEADER_EN defined: each dump SHALL begin (D_HDR) with byte 0xA5 then an 8-bit frame counter (reset 0, increments per completed dump, wraps 255->0).
REQ-032 Macro INTEG_HEADER_EN undefined: D_HDR SHALL be skipped, no frame counter exists, dump length is 2*NUM_CHANNELS bytes.

Verification
REQ-033 SAMPLE_DIV=4, int_len=3, start -> sample pulses at cycles 4,8,12 after start; integration_clk_pulse coincident with cycle-12 pulse.
REQ-034 NUM_CHANNELS=2, rd_data=addr?0x1ABC:0x0123, tx_ready held 1 -> bytes 0x01,0x23,0x1A,0xBC (header build: preceded by 0xA5,0x00).
REQ-035 tx_ready low 10 cycles mid-dump -> tx_valid held, tx_data unchanged, no byte lost or duplicated.
REQ-036 tx_ready held 0 across two integration_clk_pulses -> overrun=1, first dump resumes when tx_ready=1, second dump absent.
REQ-037 stop mid-dump -> no further sample pulses, dump finishes, busy falls after last byte accepted.
REQ-038 rst_n low mid-dump for 1 cycle -> all outputs at REQ-030 values next cycle; start then yields fresh dump (frame counter 0x00).
